kb_buf_reader: RTL

- Consumer-side engine for the keyboard scancode buffer RAM.
- The keyboard writer fills the buffer as follows:
  - Scancodes go into slots 0..TOP-1 in ring order.
  - It then writes 1 to the flag slot TOP = 2**DEPTH-1.
- This block polls the flag, clears it, and drains pending scancodes in ring order.
- Each scancode is handed to the CPU bus side over a valid/ready handshake, and each consumed slot is zeroed.
- It owns a dedicated RAM port; the RAM read is asynchronous, so data is valid the same cycle as the address.

---
 rtl/kb_buf_reader_if.sv | 26 ++
 rtl/kb_buf_reader.sv | 117 +++++++++++
 2 files changed

// File: rtl/kb_buf_reader_if.sv
// Signal bundle between the scancode reader, its dedicated RAM port and the
// CPU-side consumer. The reader drives the master side.
interface kb_buf_reader_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
);
    logic             ram_ena;
    logic             wena;
    logic [DEPTH-1:0] addr;
    logic [WIDTH-1:0] ram_wdata;
    logic [WIDTH-1:0] ram_rdata;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    modport master (
        output ram_ena, wena, addr, ram_wdata, out_data, out_valid, busy,
        input  ram_rdata, out_ready
    );

    modport slave (
        input  ram_ena, wena, addr, ram_wdata, out_data, out_valid, busy,
        output ram_rdata, out_ready
    );
endinterface

// File: rtl/kb_buf_reader.sv
// Polls the keyboard buffer flag slot, clears it, then drains pending
// scancodes in ring order to a valid/ready consumer, zeroing each slot.
module kb_buf_reader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic            clk,
    input  logic            rst,
    kb_buf_reader_if.master bus
);
    localparam logic [DEPTH-1:0] TOP  = {DEPTH{1'b1}};
    localparam logic [DEPTH-1:0] LAST = TOP - 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FETCH,
        S_PRESENT,
        S_ERASE
    } state_t;

    state_t           state_q, state_d;
    logic [DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0] scan_cnt_q, scan_cnt_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;

    logic             ram_ena;
    logic             wena;
    logic [DEPTH-1:0] addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rd_ptr_q    <= '0;
            scan_cnt_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            scan_cnt_q  <= scan_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        scan_cnt_d  = scan_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ram_ena     = 1'b0;
        wena        = 1'b0;
        addr        = TOP;

        case (state_q)
            S_IDLE: begin
                ram_ena = 1'b1;
                if (bus.ram_rdata != '0) begin
                    state_d = S_CLR;
                end
            end
            // Flag is cleared before the scan so a flag raised mid-pass
            // is seen again on the next poll.
            S_CLR: begin
                ram_ena    = 1'b1;
                wena       = 1'b1;
                scan_cnt_d = '0;
                state_d    = S_FETCH;
            end
            S_FETCH: begin
                ram_ena = 1'b1;
                addr    = rd_ptr_q;
                if (bus.ram_rdata == '0 || scan_cnt_q == TOP) begin
                    state_d = S_IDLE;
                end else begin
                    out_data_d  = bus.ram_rdata;
                    out_valid_d = 1'b1;
                    state_d     = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_ERASE;
                end
            end
            S_ERASE: begin
                ram_ena    = 1'b1;
                wena       = 1'b1;
                addr       = rd_ptr_q;
                rd_ptr_d   = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
                scan_cnt_d = scan_cnt_q + 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The RAM port stays quiet for as long as reset is held.
        if (rst) begin
            ram_ena = 1'b0;
            wena    = 1'b0;
        end
    end

    assign bus.ram_ena   = ram_ena;
    assign bus.wena      = wena;
    assign bus.addr      = addr;
    assign bus.ram_wdata = '0;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q != S_IDLE);
endmodule
